// File: rtl/bcd2ascii_serial.sv
// BCD word to ASCII character stream, MSD first, then a terminator, over valid/ready.
// Optional leading-zero suppression is compiled in with BCD2ASCII_ZERO_BLANK_EN.
module bcd2ascii_serial #(
  parameter int unsigned BCD_DIGITS = 5,
  parameter logic [7:0]  EOL_CHAR   = 8'h0A
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*BCD_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    bad_digit
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned IDX_W = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(BCD_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    TERM = 2'd2
`ifdef BCD2ASCII_ZERO_BLANK_EN
    , SKIP = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [BCD_W-1:0] digits_q, digits_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_d, valid_d, last_d, bad_d;
  logic [7:0]       data_d;

  logic             hs;
  logic [IDX_W-1:0] idx_dec;
  logic [3:0]       nxt_digit;

  // Out-of-range digits are shown as '?'.
  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  assign hs        = out_valid & out_ready;
  assign idx_dec   = idx_q - IDX_W'(1);
  assign nxt_digit = digits_q[{idx_dec, 2'b00} +: 4];

`ifdef BCD2ASCII_ZERO_BLANK_EN
  logic [3:0] cur_digit;
  assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];
`else
  logic [3:0] top_digit;
  assign top_digit = bcd_in[BCD_W-1 -: 4];
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      digits_q  <= '0;
      idx_q     <= '0;
      busy      <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      idx_q     <= idx_d;
      busy      <= busy_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      bad_digit <= bad_d;
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    idx_d    = idx_q;
    busy_d   = busy;
    data_d   = out_data;
    valid_d  = out_valid;
    last_d   = out_last;
    bad_d    = bad_digit;

    case (state_q)
      IDLE: begin
        if (load) begin
          digits_d = bcd_in;
          idx_d    = IDX_TOP;
          busy_d   = 1'b1;
          bad_d    = 1'b0;
`ifdef BCD2ASCII_ZERO_BLANK_EN
          state_d  = SKIP;
`else
          data_d   = to_ascii(top_digit);
          valid_d  = 1'b1;
          bad_d    = (top_digit > 4'd9);
          state_d  = EMIT;
`endif
        end
      end
`ifdef BCD2ASCII_ZERO_BLANK_EN
      SKIP: begin
        // Digit 0 is never blanked, so at least one character is sent.
        if (cur_digit == 4'd0 && idx_q != '0) begin
          idx_d = idx_dec;
        end else begin
          data_d  = to_ascii(cur_digit);
          valid_d = 1'b1;
          bad_d   = bad_digit | (cur_digit > 4'd9);
          state_d = EMIT;
        end
      end
`endif
      EMIT: begin
        if (hs) begin
          if (idx_q != '0) begin
            idx_d  = idx_dec;
            data_d = to_ascii(nxt_digit);
            bad_d  = bad_digit | (nxt_digit > 4'd9);
          end else begin
            data_d  = EOL_CHAR;
            last_d  = 1'b1;
            state_d = TERM;
          end
        end
      end
      TERM: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd2ascii_serial.sv
// Directed bench for bcd2ascii_serial; expectations follow BCD2ASCII_ZERO_BLANK_EN.
module tb_bcd2ascii_serial;

  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             load;
  logic [BCD_W-1:0] bcd_in;
  logic             busy;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             bad_digit;

  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  bcd2ascii_serial #(.BCD_DIGITS(BCD_DIGITS), .EOL_CHAR(8'h0A)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .bad_digit (bad_digit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_bad"},   32'(bad_digit), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'h00);
  endtask

  // Load one frame, consume it with `stall` not-ready cycles per byte, check against exp_q.
  task automatic run_frame(input logic [BCD_W-1:0] bcd, input int stall, input int lat,
                           input bit pulse_load);
    int idx = 0;
    int cyc = 1;
    int wait_cnt = 0;
    int n = exp_q.size();
    bit bad_seen = 1'b0;
    bit first = 1'b1;
    load = 1'b1;
    bcd_in = bcd;
    out_ready = 1'b0;
    step();
    load = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("bad_clear", 32'(bad_digit), 32'(lat == 1 && exp_q[0] == 8'h3F));
    while (idx < n && cyc < 400) begin
      out_ready = (wait_cnt >= stall);
      load = 1'b0;
      if (out_valid) begin
        if (first) begin
          check("first_lat", 32'(cyc), 32'(lat));
          first = 1'b0;
        end
        if (exp_q[idx] == 8'h3F) bad_seen = 1'b1;
        check("data", 32'(out_data), 32'(exp_q[idx]));
        check("last", 32'(out_last), 32'(idx == n - 1));
        check("bad_digit", 32'(bad_digit), 32'(bad_seen));
        if (out_ready) begin
          if (pulse_load && (idx == 2 || idx == n - 1)) begin
            load = 1'b1;
            bcd_in = 20'h99999;
          end
          idx++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      step();
      cyc++;
    end
    load = 1'b0;
    out_ready = 1'b0;
    if (idx < n) check("frame_timeout", 32'(idx), 32'(n));
    check("end_cycle", 32'(cyc), 32'(lat + n * (stall + 1)));
    check("busy_fall", 32'(busy), 32'd0);
    check("valid_fall", 32'(out_valid), 32'd0);
    check("bad_hold", 32'(bad_digit), 32'(bad_seen));
    step();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int hs;
    int guard;
    reset_n = 1'b0;
    load = 1'b0;
    bcd_in = '0;
    out_ready = 1'b1;
    repeat (2) step();
    check_reset_values("por");
    reset_n = 1'b1;
    step();
    check("ready_no_load_valid", 32'(out_valid), 32'd0);
    check("ready_no_load_busy", 32'(busy), 32'd0);

`ifdef BCD2ASCII_ZERO_BLANK_EN
    exp_q = '{8'h34, 8'h32, 8'h0A};
    run_frame(20'h00042, 0, 5, 1'b0);
    exp_q = '{8'h30, 8'h0A};
    run_frame(20'h00000, 0, 6, 1'b0);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0A};
    run_frame(20'h12345, 3, 2, 1'b0);
    exp_q = '{8'h31, 8'h3F, 8'h33, 8'h3F, 8'h30, 8'h0A};
    run_frame(20'h1A3F0, 0, 2, 1'b1);
`else
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h34, 8'h32, 8'h0A};
    run_frame(20'h00042, 0, 1, 1'b0);
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};
    run_frame(20'h00000, 0, 1, 1'b0);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0A};
    run_frame(20'h12345, 3, 1, 1'b0);
    exp_q = '{8'h31, 8'h3F, 8'h33, 8'h3F, 8'h30, 8'h0A};
    run_frame(20'h1A3F0, 0, 1, 1'b1);
`endif

    // Reset after the second handshake abandons the frame.
    load = 1'b1;
    bcd_in = 20'h1A3F0;
    out_ready = 1'b1;
    step();
    load = 1'b0;
    hs = 0;
    guard = 0;
    while (hs < 2 && guard < 50) begin
      if (out_valid && out_ready) hs++;
      step();
      guard++;
    end
    check("rst_two_handshakes", 32'(hs), 32'd2);
    check("rst_pre_bad", 32'(bad_digit), 32'd1);
    reset_n = 1'b0;
    step();
    check_reset_values("midrst");
    reset_n = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

`ifdef BCD2ASCII_ZERO_BLANK_EN
    exp_q = '{8'h37, 8'h0A};
    run_frame(20'h00007, 0, 6, 1'b0);
`else
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0A};
    run_frame(20'h00007, 0, 1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
